tms5200_cpu_bridge: RTL and testbench

//  CPU-side bridge for the speech subsystem. Turns single-cycle CPU read/write

---
 rtl/tms5200_cpu_bridge.sv | 144 ++++++++++++++
 tb/tb_tms5200_cpu_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tms5200_cpu_bridge.sv
// CPU-side bridge for the speech subsystem: turns one-clock CPU read/write
// requests into timed /RS or /WS strobe cycles on the VSP, with a timeout guard.
module tms5200_cpu_bridge #(
  parameter int unsigned MIN_STROBE = 2,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned RECOVERY   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [0:7] cpu_wdata,
  output logic [0:7] cpu_rdata,
  output logic       cpu_busy,
  output logic       cpu_done,
  output logic       cpu_err,
  output logic [0:7] vsp_dd,
  input  logic [0:7] vsp_dq,
  output logic       vsp_rs,
  output logic       vsp_ws,
  input  logic       vsp_rdy
);

  localparam int unsigned SW = $clog2(MIN_STROBE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RECOVERY + 1);

  localparam logic [SW-1:0] STROBE_LAST   = SW'(MIN_STROBE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RECOVERY_LAST = RW'(RECOVERY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  typedef enum logic {
    OP_WRITE,
    OP_READ
  } op_t;

  state_t        state;
  op_t           op;
  logic [SW-1:0] strobe_cnt;
  logic [TW-1:0] wait_cnt;
  logic [RW-1:0] rec_cnt;
  logic          err_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      op         <= OP_WRITE;
      strobe_cnt <= '0;
      wait_cnt   <= '0;
      rec_cnt    <= '0;
      err_flag   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      vsp_dd     <= '0;
      vsp_rs     <= 1'b1;
      vsp_ws     <= 1'b1;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;

      case (state)
        // Request acceptance is not gated by clk_en; write wins a tie.
        ST_IDLE: begin
          if (cpu_wr) begin
            vsp_dd   <= cpu_wdata;
            op       <= OP_WRITE;
            vsp_ws   <= 1'b0;
            cpu_busy <= 1'b1;
            state    <= ST_ASSERT;
          end else if (cpu_rd) begin
            op       <= OP_READ;
            vsp_rs   <= 1'b0;
            cpu_busy <= 1'b1;
            state    <= ST_ASSERT;
          end
        end

        ST_ASSERT: begin
          if (clk_en) begin
            if (strobe_cnt == STROBE_LAST) begin
              state <= ST_WAIT;
            end else begin
              strobe_cnt <= strobe_cnt + 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (clk_en) begin
            if (vsp_rdy) begin
              if (op == OP_READ) begin
                cpu_rdata <= vsp_dq;
              end
              vsp_rs <= 1'b1;
              vsp_ws <= 1'b1;
              state  <= ST_RELEASE;
            end else if (wait_cnt == TIMEOUT_LAST) begin
              if (op == OP_READ) begin
                cpu_rdata <= '1;
              end
              wait_cnt <= wait_cnt + 1'b1;
              err_flag <= 1'b1;
              vsp_rs   <= 1'b1;
              vsp_ws   <= 1'b1;
              state    <= ST_RELEASE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end

        ST_RELEASE: begin
          if (clk_en) begin
            if (rec_cnt == RECOVERY_LAST) begin
              cpu_done   <= 1'b1;
              cpu_err    <= err_flag;
              cpu_busy   <= 1'b0;
              strobe_cnt <= '0;
              wait_cnt   <= '0;
              rec_cnt    <= '0;
              err_flag   <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              rec_cnt <= rec_cnt + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tms5200_cpu_bridge.sv
// Bench for tms5200_cpu_bridge: tick-count transaction model checked every
// cycle, plus directed scenarios with hand-computed latencies and data.
module tb_tms5200_cpu_bridge;

  localparam int MIN_STROBE = 2;
  localparam int TIMEOUT    = 64;
  localparam int RECOVERY   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [0:7] cpu_wdata = '0;
  logic [0:7] cpu_rdata;
  logic       cpu_busy;
  logic       cpu_done;
  logic       cpu_err;
  logic [0:7] vsp_dd;
  logic [0:7] vsp_dq = '0;
  logic       vsp_rs;
  logic       vsp_ws;
  logic       vsp_rdy = 1'b0;

  tms5200_cpu_bridge #(
    .MIN_STROBE(MIN_STROBE),
    .TIMEOUT   (TIMEOUT),
    .RECOVERY  (RECOVERY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_busy (cpu_busy),
    .cpu_done (cpu_done),
    .cpu_err  (cpu_err),
    .vsp_dd   (vsp_dd),
    .vsp_dq   (vsp_dq),
    .vsp_rs   (vsp_rs),
    .vsp_ws   (vsp_ws),
    .vsp_rdy  (vsp_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever #5 clk = ~clk;

  // clk_en on every 4th clock
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #2;
      div = (div + 1) % 4;
      clk_en = (div == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction model: counts clk_en ticks since the strobe fell
  logic       e_busy = 1'b0, e_rs = 1'b1, e_ws = 1'b1, e_done = 1'b0, e_err = 1'b0;
  logic [0:7] e_dd = '0, e_rdata = '0;
  logic       m_busy = 1'b0, m_read = 1'b0, m_to = 1'b0;
  int         m_ticks = 0, m_rel = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; e_busy = 1'b0; e_rs = 1'b1; e_ws = 1'b1;
      e_dd = '0; e_rdata = '0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_done = 1'b0;
      e_err  = 1'b0;
      if (!m_busy) begin
        if (cpu_wr || cpu_rd) begin
          m_busy = 1'b1; m_ticks = 0; m_rel = 0; m_to = 1'b0;
          m_read = !cpu_wr;
          if (cpu_wr) begin
            e_dd = cpu_wdata;
            e_ws = 1'b0;
          end else begin
            e_rs = 1'b0;
          end
        end
      end else if (clk_en) begin
        m_ticks++;
        if (m_rel == 0) begin
          if (m_ticks > MIN_STROBE && (vsp_rdy || m_ticks == MIN_STROBE + TIMEOUT)) begin
            m_rel = m_ticks;
            m_to  = !vsp_rdy;
            if (m_read) e_rdata = vsp_rdy ? vsp_dq : 8'hFF;
            e_rs = 1'b1;
            e_ws = 1'b1;
          end
        end else if (m_ticks == m_rel + RECOVERY) begin
          e_done = 1'b1;
          e_err  = m_to;
          m_busy = 1'b0;
        end
      end
      e_busy = m_busy;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cpu_busy", int'(cpu_busy), int'(e_busy));
      chk("cpu_done", int'(cpu_done), int'(e_done));
      chk("cpu_err", int'(cpu_err), int'(e_err));
      chk("cpu_rdata", int'(cpu_rdata), int'(e_rdata));
      chk("vsp_dd", int'(vsp_dd), int'(e_dd));
      chk("vsp_rs", int'(vsp_rs), int'(e_rs));
      chk("vsp_ws", int'(vsp_ws), int'(e_ws));
    end
  end

  // Monitor: cumulative counters used by the directed checks
  int tick_no = 0;
  int last_low_tick = 0, last_done_tick = 0;
  int done_cnt = 0, err_cnt = 0, ws_low_ticks = 0, rs_low_ticks = 0;
  logic prev_strobe = 1'b1;

  always @(posedge clk) if (clk_en) tick_no++;

  always @(negedge clk) begin
    if (prev_strobe && !(vsp_rs && vsp_ws)) last_low_tick = tick_no;
    prev_strobe = vsp_rs && vsp_ws;
    if (clk_en && !vsp_ws) ws_low_ticks++;
    if (clk_en && !vsp_rs) rs_low_ticks++;
    if (cpu_done) begin
      done_cnt++;
      last_done_tick = tick_no;
      if (cpu_err) err_cnt++;
    end
  end

  task automatic pulse(input logic rd, input logic wr, input logic [0:7] d);
    @(posedge clk);
    #3;
    cpu_rd = rd; cpu_wr = wr; cpu_wdata = d;
    @(posedge clk);
    #3;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!clk_en) @(posedge clk);
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_done && n < max_cycles);
    if (!cpu_done) begin
      n_fail++;
      $display("FAIL %s: cpu_done not seen within %0d cycles", name, max_cycles);
    end
    @(negedge clk);
  endtask

  int d0, e0, w0, r0;

  initial begin
    repeat (3) @(posedge clk);
    #3;
    cmp_en = 1'b1;
    chk("reset_busy", int'(cpu_busy), 0);
    chk("reset_rs", int'(vsp_rs), 1);
    chk("reset_ws", int'(vsp_ws), 1);
    chk("reset_dd", int'(vsp_dd), 0);
    chk("reset_rdata", int'(cpu_rdata), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // Write A5, rdy already high
    vsp_rdy = 1'b1;
    d0 = done_cnt; e0 = err_cnt; w0 = ws_low_ticks; r0 = rs_low_ticks;
    pulse(1'b0, 1'b1, 8'hA5);
    wait_done("wr_done", 100);
    chk("wr_latency", last_done_tick - last_low_tick, 4);
    chk("wr_ws_low_ticks", ws_low_ticks - w0, 3);
    chk("wr_rs_low_ticks", rs_low_ticks - r0, 0);
    chk("wr_dd", int'(vsp_dd), 'hA5);
    chk("wr_done_cnt", done_cnt - d0, 1);
    chk("wr_err_cnt", err_cnt - e0, 0);

    // Read 3C, rdy raised after 5 WAIT ticks
    vsp_rdy = 1'b0; vsp_dq = 8'h3C;
    d0 = done_cnt; w0 = ws_low_ticks; r0 = rs_low_ticks;
    pulse(1'b1, 1'b0, 8'h00);
    repeat (MIN_STROBE + 5) wait_tick();
    #3 vsp_rdy = 1'b1;
    wait_done("rd_done", 100);
    chk("rd_rdata", int'(cpu_rdata), 'h3C);
    chk("rd_latency", last_done_tick - last_low_tick, 9);
    chk("rd_rs_low_ticks", rs_low_ticks - r0, 8);
    chk("rd_ws_low_ticks", ws_low_ticks - w0, 0);
    chk("rd_dd_kept", int'(vsp_dd), 'hA5);

    // Read with hung VSP: timeout
    vsp_rdy = 1'b0; vsp_dq = 8'h5E;
    d0 = done_cnt; e0 = err_cnt;
    pulse(1'b1, 1'b0, 8'h00);
    wait_done("to_done", 400);
    chk("to_latency", last_done_tick - last_low_tick, MIN_STROBE + TIMEOUT + RECOVERY);
    chk("to_err_cnt", err_cnt - e0, 1);
    chk("to_rdata", int'(cpu_rdata), 'hFF);
    chk("to_busy_after", int'(cpu_busy), 0);

    // Simultaneous read and write: write wins
    vsp_rdy = 1'b1;
    d0 = done_cnt; r0 = rs_low_ticks;
    pulse(1'b1, 1'b1, 8'h12);
    wait_done("both_done", 100);
    chk("both_rs_low_ticks", rs_low_ticks - r0, 0);
    chk("both_dd", int'(vsp_dd), 'h12);
    chk("both_rdata_kept", int'(cpu_rdata), 'hFF);
    repeat (10) @(negedge clk);
    chk("both_done_cnt", done_cnt - d0, 1);

    // Second write while busy is ignored
    vsp_rdy = 1'b0;
    d0 = done_cnt;
    pulse(1'b0, 1'b1, 8'h77);
    wait_tick();
    pulse(1'b0, 1'b1, 8'h99);
    wait_tick();
    #3 vsp_rdy = 1'b1;
    wait_done("busy_done", 200);
    repeat (40) @(negedge clk);
    chk("busy_done_cnt", done_cnt - d0, 1);
    chk("busy_dd", int'(vsp_dd), 'h77);

    // Reset during WAIT
    vsp_rdy = 1'b0;
    d0 = done_cnt;
    pulse(1'b1, 1'b0, 8'h00);
    repeat (MIN_STROBE + 2) wait_tick();
    #3 reset = 1'b0;
    #1;
    chk("rst_busy", int'(cpu_busy), 0);
    chk("rst_rs", int'(vsp_rs), 1);
    chk("rst_ws", int'(vsp_ws), 1);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);

    vsp_rdy = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    pulse(1'b0, 1'b1, 8'h5A);
    wait_done("post_rst_done", 100);
    chk("post_rst_latency", last_done_tick - last_low_tick, 4);
    chk("post_rst_dd", int'(vsp_dd), 'h5A);
    chk("post_rst_err", err_cnt - e0, 0);
    chk("post_rst_done_cnt", done_cnt - d0, 1);

    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
